// File: rtl/mouse_tracker.sv
// mouse_tracker: debounced button plus a single-axis quadrature position tracker.
//
// All three asynchronous inputs pass through 2-flop synchronizers. The button is
// debounced by a run-length counter. The quadrature phases are decoded against
// the previous synchronized phase to step a saturating X position.
//
// Ports
//   clock          rising-edge system clock
//   reset_         synchronous, active-high reset
//   button_raw     asynchronous, bouncy button (1 = pressed)
//   quad_a/quad_b  asynchronous quadrature phases, X axis
//   mouse_pressed_ debounced button (1 = pressed)
//   mouse_x        saturating X position, range 0..X_MAX
//   x_moved        one-cycle pulse following each edge where mouse_x changed
//   quad_error     sticky flag for a transition with both phase bits changed
module mouse_tracker #(
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [15:0] X_MAX           = 16'd639,
  parameter logic [15:0] X_RESET         = 16'd0
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        button_raw,
  input  logic        quad_a,
  input  logic        quad_b,
  output logic        mouse_pressed_,
  output logic [15:0] mouse_x,
  output logic        x_moved,
  output logic        quad_error
);

  // The counter only has to hold 0..DEBOUNCE_CYCLES-1: on the cycle it would
  // reach DEBOUNCE_CYCLES the output toggles and the counter clears instead.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Apply a signed unit step to the position, clamping to [0, X_MAX].
  function automatic logic [15:0] sat_step(input logic [15:0] x,
                                           input logic signed [1:0] step);
    logic signed [17:0] sum;
    sum = $signed({2'b00, x}) + $signed({{16{step[1]}}, step});
    if (sum < 18'sd0) begin
      return 16'd0;
    end else if (sum > $signed({2'b00, X_MAX})) begin
      return X_MAX;
    end else begin
      return sum[15:0];
    end
  endfunction

  // ---- stage p0/p1: 2-flop synchronizers {button, a, b} ----
  logic [2:0] sync_p0;
  logic [2:0] sync_p1;

  always_ff @(posedge clock) begin
    if (reset_) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {button_raw, quad_a, quad_b};
      sync_p1 <= sync_p0;
    end
  end

  logic       button_s;
  logic [1:0] phase_s;

  assign button_s = sync_p1[2];
  assign phase_s  = sync_p1[1:0];

  // ---- stage p2: button debounce ----
  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge clock) begin
    if (reset_) begin
      db_cnt         <= '0;
      mouse_pressed_ <= 1'b0;
    end else if (button_s != mouse_pressed_) begin
      if (db_cnt == CNT_LAST) begin
        db_cnt         <= '0;
        mouse_pressed_ <= ~mouse_pressed_;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // ---- stage p2: quadrature decode and position ----
  logic [1:0]        phase_prev_p2;
  logic [1:0]        arm_cnt;
  logic              armed;
  logic signed [1:0] step;
  logic              illegal;
  logic [15:0]       x_next;

  // After reset the synchronizers and prev still hold the cleared phase 00,
  // so the first three edges only refill prev; otherwise a phase of 11 held
  // through reset would look like an illegal 00->11 jump.
  assign armed = (arm_cnt == 2'd3);

  always_comb begin
    step    = 2'sd0;
    illegal = 1'b0;
    case ({phase_prev_p2, phase_s})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step    = 2'sd1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step    = -2'sd1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
      default:                                step    = 2'sd0;
    endcase
    x_next = armed ? sat_step(mouse_x, step) : mouse_x;
  end

  always_ff @(posedge clock) begin
    if (reset_) begin
      phase_prev_p2 <= 2'b00;
      arm_cnt       <= 2'd0;
      mouse_x       <= X_RESET;
      x_moved       <= 1'b0;
      quad_error    <= 1'b0;
    end else begin
      phase_prev_p2 <= phase_s;
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
      mouse_x <= x_next;
      // A clamped step leaves x_next equal to mouse_x, so no pulse.
      x_moved <= (x_next != mouse_x);
      if (armed && illegal) begin
        quad_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mouse_tracker.sv
// Bench for mouse_tracker: directed scenarios plus a randomized run, all
// checked against a sample-history model of the tracker's behaviour.
module tb_mouse_tracker;

  localparam int          D    = 4;
  localparam logic [15:0] XMAX = 16'd639;
  localparam logic [15:0] XRST = 16'd0;
  localparam int          HIST = 8192;

  logic        clock      = 1'b0;
  logic        reset_     = 1'b1;
  logic        button_raw = 1'b0;
  logic        quad_a     = 1'b0;
  logic        quad_b     = 1'b0;
  logic        mouse_pressed_;
  logic [15:0] mouse_x;
  logic        x_moved;
  logic        quad_error;

  int n_cmp = 0;
  int n_err = 0;

  mouse_tracker #(
    .DEBOUNCE_CYCLES(D),
    .X_MAX          (XMAX),
    .X_RESET        (XRST)
  ) dut (
    .clock         (clock),
    .reset_        (reset_),
    .button_raw    (button_raw),
    .quad_a        (quad_a),
    .quad_b        (quad_b),
    .mouse_pressed_(mouse_pressed_),
    .mouse_x       (mouse_x),
    .x_moved       (x_moved),
    .quad_error    (quad_error)
  );

  always #5 clock = ~clock;

  // Phase order going forward: 00 -> 10 -> 11 -> 01 -> 00
  logic [1:0] ph_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  function automatic int pos_of(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // ------------------------------------------------------------------
  // Reference model: every rising edge records the raw inputs. An input
  // sampled at edge e is what the logic acts on at edge e+2, and the
  // previous phase seen there is the one sampled at edge e-1. Samples
  // taken at or before the latest reset edge count as zero.
  // ------------------------------------------------------------------
  int          edge_no  = 0;
  int          last_rst = 0;
  int          last_tog = 0;
  logic [1:0]  ph_at  [HIST];
  logic        btn_at [HIST];
  logic [15:0] m_x     = XRST;
  logic        m_press = 1'b0;
  logic        m_moved = 1'b0;
  logic        m_err   = 1'b0;

  function automatic logic [1:0] eff_ph(input int e);
    if (e <= last_rst || e < 1) return 2'b00;
    return ph_at[e];
  endfunction

  function automatic logic eff_btn(input int e);
    if (e <= last_rst || e < 1) return 1'b0;
    return btn_at[e];
  endfunction

  initial begin
    int d;
    bit stable;
    forever begin
      @(posedge clock);
      edge_no++;
      ph_at[edge_no]  = {quad_a, quad_b};
      btn_at[edge_no] = button_raw;
      if (reset_) begin
        last_rst = edge_no;
        last_tog = edge_no;
        m_x      = XRST;
        m_press  = 1'b0;
        m_moved  = 1'b0;
        m_err    = 1'b0;
      end else begin
        m_moved = 1'b0;
        // Position: quarter-turn distance between consecutive phases.
        if (edge_no - last_rst >= 4) begin
          d = (pos_of(eff_ph(edge_no - 2)) - pos_of(eff_ph(edge_no - 3)) + 4) % 4;
          if (d == 1 && m_x < XMAX) begin
            m_x = m_x + 16'd1;
            m_moved = 1'b1;
          end else if (d == 3 && m_x > 16'd0) begin
            m_x = m_x - 16'd1;
            m_moved = 1'b1;
          end else if (d == 2) begin
            m_err = 1'b1;
          end
        end
        // Button: toggle when the last D edges since the latest reset or
        // toggle all saw a synchronized level different from the output.
        stable = 1'b1;
        for (int j = edge_no - D + 1; j <= edge_no; j++) begin
          if (j <= last_rst || j <= last_tog || eff_btn(j - 2) == m_press) stable = 1'b0;
        end
        if (stable) begin
          m_press  = ~m_press;
          last_tog = edge_no;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers (no checking)
  // ------------------------------------------------------------------
  task automatic set_quad(input logic [1:0] p);
    {quad_a, quad_b} = p;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset_ = 1'b1;
    repeat (cycles) @(negedge clock);
    reset_ = 1'b0;
  endtask

  // ------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------
  task automatic test_reset();
    button_raw = 1'b0;
    set_quad(2'b00);
    do_reset(2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({mouse_pressed_, mouse_x, x_moved, quad_error} !== {m_press, m_x, m_moved, m_err}) begin
        n_err++;
        $display("FAIL reset_idle c=%0d: got p=%0b x=%0d mv=%0b qe=%0b want p=%0b x=%0d mv=%0b qe=%0b",
                 c, mouse_pressed_, mouse_x, x_moved, quad_error, m_press, m_x, m_moved, m_err);
      end
    end
    n_cmp++;
    if ({mouse_pressed_, mouse_x, x_moved, quad_error} !== {1'b0, XRST, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: got p=%0b x=%0d mv=%0b qe=%0b want p=0 x=%0d mv=0 qe=0",
               mouse_pressed_, mouse_x, x_moved, quad_error, XRST);
    end
  endtask

  task automatic test_forward_seq();
    logic [1:0] seq [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    int  pulses = 0;
    logic exp_mv;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({mouse_pressed_, mouse_x, x_moved, quad_error} !== {m_press, m_x, m_moved, m_err}) begin
        n_err++;
        $display("FAIL fwd_seq c=%0d: got p=%0b x=%0d mv=%0b qe=%0b want p=%0b x=%0d mv=%0b qe=%0b",
                 c, mouse_pressed_, mouse_x, x_moved, quad_error, m_press, m_x, m_moved, m_err);
      end
      // Steps are driven at c=3,6,9,12; each pulse is seen three negedges later.
      exp_mv = (c == 6 || c == 9 || c == 12 || c == 15);
      n_cmp++;
      if (x_moved !== exp_mv) begin
        n_err++;
        $display("FAIL fwd_pulse_timing c=%0d: got x_moved=%0b want %0b", c, x_moved, exp_mv);
      end
      if (x_moved === 1'b1) pulses++;
      if (c % 3 == 0 && c < 15) set_quad(seq[c / 3]);
    end
    n_cmp++;
    if (mouse_x !== 16'd4 || pulses != 4) begin
      n_err++;
      $display("FAIL fwd_total: got x=%0d pulses=%0d want x=4 pulses=4", mouse_x, pulses);
    end
  endtask

  task automatic test_saturation();
    int  idx;
    int  pulses = 0;
    bit  mv_seen = 1'b0;
    set_quad(2'b00);
    do_reset(1);
    for (int c = 0; c < 4; c++) @(negedge clock);
    set_quad(2'b01);  // one reverse step at position 0
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (x_moved === 1'b1) mv_seen = 1'b1;
      n_cmp++;
      if ({mouse_pressed_, mouse_x, x_moved, quad_error} !== {m_press, m_x, m_moved, m_err}) begin
        n_err++;
        $display("FAIL sat_low c=%0d: got p=%0b x=%0d mv=%0b qe=%0b want p=%0b x=%0d mv=%0b qe=%0b",
                 c, mouse_pressed_, mouse_x, x_moved, quad_error, m_press, m_x, m_moved, m_err);
      end
    end
    n_cmp++;
    if (mouse_x !== 16'd0 || mv_seen) begin
      n_err++;
      $display("FAIL sat_low_hold: got x=%0d moved_seen=%0b want x=0 moved_seen=0", mouse_x, mv_seen);
    end
    // 645 forward steps from 0: the last six land on the upper limit.
    idx = 3;
    for (int i = 0; i < 650; i++) begin
      @(negedge clock);
      if (x_moved === 1'b1) pulses++;
      n_cmp++;
      if ({mouse_pressed_, mouse_x, x_moved, quad_error} !== {m_press, m_x, m_moved, m_err}) begin
        n_err++;
        $display("FAIL sat_walk i=%0d: got p=%0b x=%0d mv=%0b qe=%0b want p=%0b x=%0d mv=%0b qe=%0b",
                 i, mouse_pressed_, mouse_x, x_moved, quad_error, m_press, m_x, m_moved, m_err);
      end
      if (i < 645) begin
        idx = (idx + 1) % 4;
        set_quad(ph_tab[idx]);
      end
    end
    n_cmp++;
    if (mouse_x !== XMAX || pulses != 639) begin
      n_err++;
      $display("FAIL sat_high_hold: got x=%0d pulses=%0d want x=%0d pulses=639", mouse_x, pulses, XMAX);
    end
  endtask

  task automatic test_debounce();
    logic exp_p;
    set_quad(2'b00);
    button_raw = 1'b0;
    do_reset(1);
    for (int c = 0; c < 4; c++) @(negedge clock);
    // Glitches 1,0 then a held 1 from c=2; the output rises at c=2+6.
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      exp_p = (c >= 8);
      n_cmp++;
      if (mouse_pressed_ !== exp_p) begin
        n_err++;
        $display("FAIL debounce_rise c=%0d: got pressed=%0b want %0b", c, mouse_pressed_, exp_p);
      end
      n_cmp++;
      if ({mouse_pressed_, mouse_x, x_moved, quad_error} !== {m_press, m_x, m_moved, m_err}) begin
        n_err++;
        $display("FAIL debounce_model c=%0d: got p=%0b x=%0d mv=%0b qe=%0b want p=%0b x=%0d mv=%0b qe=%0b",
                 c, mouse_pressed_, mouse_x, x_moved, quad_error, m_press, m_x, m_moved, m_err);
      end
      if (c == 0) button_raw = 1'b1;
      if (c == 1) button_raw = 1'b0;
      if (c == 2) button_raw = 1'b1;
      if (c == 15) button_raw = 1'b0;
    end
    for (int c = 0; c < 10; c++) @(negedge clock);
    n_cmp++;
    if (mouse_pressed_ !== 1'b0) begin
      n_err++;
      $display("FAIL debounce_release: got pressed=%0b want 0", mouse_pressed_);
    end
  endtask

  task automatic test_quad_error();
    int idx;
    set_quad(2'b00);
    do_reset(1);
    for (int c = 0; c < 5; c++) @(negedge clock);
    set_quad(2'b11);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({mouse_pressed_, mouse_x, x_moved, quad_error} !== {m_press, m_x, m_moved, m_err}) begin
        n_err++;
        $display("FAIL qerr_jump c=%0d: got p=%0b x=%0d mv=%0b qe=%0b want p=%0b x=%0d mv=%0b qe=%0b",
                 c, mouse_pressed_, mouse_x, x_moved, quad_error, m_press, m_x, m_moved, m_err);
      end
    end
    n_cmp++;
    if (quad_error !== 1'b1 || mouse_x !== 16'd0) begin
      n_err++;
      $display("FAIL qerr_set: got qe=%0b x=%0d want qe=1 x=0", quad_error, mouse_x);
    end
    idx = 2;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({mouse_pressed_, mouse_x, x_moved, quad_error} !== {m_press, m_x, m_moved, m_err}) begin
        n_err++;
        $display("FAIL qerr_walk c=%0d: got p=%0b x=%0d mv=%0b qe=%0b want p=%0b x=%0d mv=%0b qe=%0b",
                 c, mouse_pressed_, mouse_x, x_moved, quad_error, m_press, m_x, m_moved, m_err);
      end
      idx = (c < 10) ? (idx + 1) % 4 : (idx + 3) % 4;
      set_quad(ph_tab[idx]);
    end
    n_cmp++;
    if (quad_error !== 1'b1) begin
      n_err++;
      $display("FAIL qerr_sticky: got qe=%0b want 1", quad_error);
    end
    do_reset(1);
    n_cmp++;
    if (quad_error !== 1'b0) begin
      n_err++;
      $display("FAIL qerr_clear: got qe=%0b want 0", quad_error);
    end
  endtask

  task automatic test_arming();
    @(negedge clock);
    reset_ = 1'b1;
    set_quad(2'b11);
    repeat (2) @(negedge clock);
    reset_ = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({mouse_pressed_, mouse_x, x_moved, quad_error} !== {m_press, m_x, m_moved, m_err}) begin
        n_err++;
        $display("FAIL arming c=%0d: got p=%0b x=%0d mv=%0b qe=%0b want p=%0b x=%0d mv=%0b qe=%0b",
                 c, mouse_pressed_, mouse_x, x_moved, quad_error, m_press, m_x, m_moved, m_err);
      end
    end
    n_cmp++;
    if (quad_error !== 1'b0 || mouse_x !== XRST) begin
      n_err++;
      $display("FAIL arming_11: got qe=%0b x=%0d want qe=0 x=%0d", quad_error, mouse_x, XRST);
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic exp_p;
    set_quad(2'b00);
    button_raw = 1'b0;
    do_reset(1);
    for (int c = 0; c < 4; c++) @(negedge clock);
    // Press at c=0; the count is 2 when reset hits on the edge after c=4.
    // Without the reset the output would rise at c=6; with it, at c=11.
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      exp_p = (c >= 11);
      n_cmp++;
      if (mouse_pressed_ !== exp_p) begin
        n_err++;
        $display("FAIL reset_mid_debounce c=%0d: got pressed=%0b want %0b", c, mouse_pressed_, exp_p);
      end
      if (c == 0) button_raw = 1'b1;
      if (c == 4) reset_ = 1'b1;
      if (c == 5) reset_ = 1'b0;
    end
    button_raw = 1'b0;
  endtask

  task automatic test_random();
    int idx;
    int r;
    int hold_b = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({mouse_pressed_, mouse_x, x_moved, quad_error} !== {m_press, m_x, m_moved, m_err}) begin
        n_err++;
        $display("FAIL random i=%0d: got p=%0b x=%0d mv=%0b qe=%0b want p=%0b x=%0d mv=%0b qe=%0b",
                 i, mouse_pressed_, mouse_x, x_moved, quad_error, m_press, m_x, m_moved, m_err);
      end
      reset_ = ($urandom_range(0, 299) == 0);
      idx = pos_of({quad_a, quad_b});
      r = $urandom_range(0, 99);
      if (r < 35)      idx = idx + 1;
      else if (r < 55) idx = idx + 3;
      else if (r < 57) idx = idx + 2;
      set_quad(ph_tab[idx % 4]);
      if (hold_b == 0) begin
        button_raw = $urandom_range(0, 1);
        hold_b     = $urandom_range(1, 9);
      end else begin
        hold_b--;
      end
    end
    reset_ = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward_seq();
    test_saturation();
    test_debounce();
    test_quad_error();
    test_arming();
    test_reset_mid_debounce();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
